// File: rtl/distro_ram_dp.sv
// distro_ram_dp: simple-dual-port distributed RAM with a registered read,
// an optional second output stage, write/read collision forwarding and a
// built-in clear sweep that initialises every word after reset or on request.
module distro_ram_dp #(
  parameter int               WIDTH     = 8,
  parameter int               LOG_DEP   = 3,
  parameter int               OUT_REG   = 0,
  parameter int               BYPASS    = 1,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  output logic               busy,
  input  logic               wen,
  input  logic [LOG_DEP-1:0] waddr,
  input  logic [WIDTH-1:0]   din,
  input  logic               ren,
  input  logic [LOG_DEP-1:0] raddr,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid
);

  localparam int DEPTH = 1 << LOG_DEP;
  // Number of read register stages between the array and dout.
  localparam int STG   = (OUT_REG != 0) ? 2 : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nx;
  logic [LOG_DEP-1:0]   clr_ptr, clr_ptr_nx;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic                 wr_acc, rd_acc, fwd;
  logic [WIDTH-1:0]     rd_word;

  // Read pipeline: stage 1 is the registered array read, stage 2 the
  // optional output register; dout/valid come from the last stage.
  logic [STG:1]              vld_pipe;
  logic [STG:1][WIDTH-1:0]   dat_pipe;

  // Host ports only act while no sweep is running.
  assign wr_acc = (state == IDLE) && wen;
  assign rd_acc = (state == IDLE) && ren;

  // Same-address write in the same cycle: forward din (write-first) or let
  // the array supply the pre-write word (read-first).
  assign fwd     = (BYPASS != 0) && wen && (waddr == raddr);
  assign rd_word = fwd ? din : mem[raddr];

  // Sweep control: IDLE waits for a clear request, CLEAR walks every address
  // once and wraps the pointer back to 0 on the last word.
  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    case (state)
      IDLE: begin
        if (clear) state_nx = CLEAR;
      end
      CLEAR: begin
        clr_ptr_nx = clr_ptr + 1'b1;
        if (&clr_ptr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset always (re)starts a full sweep from address 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end

  assign busy = (state == CLEAR);

  // Array write port: sweep writes take over the port, nothing lands during reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_ptr] <= CLEAR_VAL;
      else if (wr_acc)
        mem[waddr] <= din;
    end
  end

  // Read pipeline: valid bits shift every cycle, data only advances with a
  // valid so every stage holds its last word when nothing is read.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      if (rd_acc) dat_pipe[1] <= rd_word;
      for (int s = 2; s <= STG; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign dout       = dat_pipe[STG];
  assign dout_valid = vld_pipe[STG];

endmodule

// File: tb/tb_distro_ram_dp.sv
// tb_distro_ram_dp: drives two RAM configurations with the same directed
// vectors (u0: latency 1, write-first, clear to 00; u1: latency 2,
// read-first, clear to 5A). Expected read data is queued at issue time and
// popped by per-instance monitors whenever dout_valid is seen.
module tb_distro_ram_dp;

  localparam logic [7:0] CV0 = 8'h00;
  localparam logic [7:0] CV1 = 8'h5A;

  logic       clk = 1'b0;
  logic       reset, clear, wen, ren;
  logic [2:0] waddr, raddr;
  logic [7:0] din;
  logic       busy0, busy1, dv0, dv1;
  logic [7:0] dout0, dout1;

  int total = 0;
  int bad   = 0;

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  always #5 clk = ~clk;

  distro_ram_dp #(.WIDTH(8), .LOG_DEP(3), .OUT_REG(0), .BYPASS(1), .CLEAR_VAL(CV0)) u0 (
    .clock(clk), .reset(reset), .clear(clear), .busy(busy0),
    .wen(wen), .waddr(waddr), .din(din),
    .ren(ren), .raddr(raddr), .dout(dout0), .dout_valid(dv0)
  );

  distro_ram_dp #(.WIDTH(8), .LOG_DEP(3), .OUT_REG(1), .BYPASS(0), .CLEAR_VAL(CV1)) u1 (
    .clock(clk), .reset(reset), .clear(clear), .busy(busy1),
    .wen(wen), .waddr(waddr), .din(din),
    .ren(ren), .raddr(raddr), .dout(dout1), .dout_valid(dv1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [7:0] e0, input logic [7:0] e1);
    q0.push_back(e0);
    q1.push_back(e1);
  endtask

  // Count busy-high samples over a fixed window starting at the next negedge.
  task automatic busy_window(input string nm);
    int n0 = 0;
    int n1 = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy0) n0++;
      if (busy1) n1++;
    end
    chk({nm, "_u0"}, n0, 8);
    chk({nm, "_u1"}, n1, 8);
  endtask

  // Monitor for u0: every valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dv0 === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL u0_unexpected_valid got=%0h want=no_read", dout0);
      end else begin
        chk("u0_rd", dout0, q0.pop_front());
      end
    end
  end

  // Monitor for u1.
  always @(negedge clk) begin
    if (dv1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL u1_unexpected_valid got=%0h want=no_read", dout1);
      end else begin
        chk("u1_rd", dout1, q1.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  logic [7:0] wa [8];
  logic [7:0] wd [8];
  logic [7:0] rexp [8];

  initial begin
    reset = 1'b1; clear = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; din = '0;

    // 1. post-reset clear
    step(); step();
    chk("rst_busy0", busy0, 1);
    chk("rst_busy1", busy1, 1);
    chk("rst_dv0", dv0, 0);
    chk("rst_dv1", dv1, 0);
    chk("rst_dout0", dout0, 0);
    chk("rst_dout1", dout1, 0);
    reset = 1'b0;
    busy_window("rst_busy_len");
    step();
    for (int i = 0; i < 8; i++) begin
      ren = 1'b1; raddr = 3'(i); expect_rd(CV0, CV1); step();
    end
    ren = 1'b0;
    step(); step();

    // 2. write / readback, scrambled write order
    wa = '{8'd0, 8'd2, 8'd5, 8'd1, 8'd4, 8'd3, 8'd7, 8'd6};
    wd = '{8'hCA, 8'hBE, 8'hDF, 8'hEA, 8'h99, 8'h80, 8'h35, 8'h22};
    rexp = '{8'hCA, 8'hEA, 8'hBE, 8'h80, 8'h99, 8'hDF, 8'h22, 8'h35};
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; waddr = wa[i][2:0]; din = wd[i]; step();
    end
    wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ren = 1'b1; raddr = 3'(i); expect_rd(rexp[i], rexp[i]); step();
      if (i == 0) begin
        chk("lat1_dv0", dv0, 1);
        chk("lat1_dv1", dv1, 0);
      end
      if (i == 1) chk("lat2_dv1", dv1, 1);
    end
    ren = 1'b0;
    step(); step();

    // 3. collision on address 2 (holds BE)
    wen = 1'b1; waddr = 3'd2; din = 8'h55; ren = 1'b1; raddr = 3'd2;
    expect_rd(8'h55, 8'hBE);
    step();
    wen = 1'b0;
    expect_rd(8'h55, 8'h55);
    step();
    ren = 1'b0;
    step(); step();

    // 6. hold after reading 99
    ren = 1'b1; raddr = 3'd4; expect_rd(8'h99, 8'h99); step();
    ren = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_dv0", dv0, 0);
      chk("hold_dv1", dv1, 0);
      chk("hold_dout0", dout0, 8'h99);
      chk("hold_dout1", dout1, 8'h99);
    end
    step();

    // 4. clear request with port activity during the sweep
    clear = 1'b1; step();
    clear = 1'b0;
    wen = 1'b1; waddr = 3'd3; din = 8'hAA; ren = 1'b1; raddr = 3'd3;
    begin
      int n0 = 0;
      int n1 = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (i == 1) begin wen = 1'b0; ren = 1'b0; end
        if (busy0) n0++;
        if (busy1) n1++;
        chk("clr_dv0", dv0, 0);
        chk("clr_dv1", dv1, 0);
        chk("clr_dout0", dout0, 8'h99);
        chk("clr_dout1", dout1, 8'h99);
      end
      chk("clr_busy_len_u0", n0, 8);
      chk("clr_busy_len_u1", n1, 8);
    end
    step();
    for (int i = 0; i < 8; i++) begin
      ren = 1'b1; raddr = 3'(i); expect_rd(CV0, CV1); step();
    end
    ren = 1'b0;
    step(); step();

    // 5. reset with a read in flight, then reset in the middle of a sweep
    ren = 1'b1; raddr = 3'd2; q0.push_back(CV0);
    step();
    ren = 1'b0; reset = 1'b1;
    step();
    chk("flight_dv1", dv1, 0);
    chk("flight_dout1", dout1, 0);
    chk("flight_busy0", busy0, 1);
    chk("flight_busy1", busy1, 1);
    reset = 1'b0;
    repeat (4) step();
    chk("mid_busy0", busy0, 1);
    chk("mid_busy1", busy1, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    busy_window("mid_busy_len");
    step();
    for (int i = 0; i < 4; i++) begin
      ren = 1'b1; raddr = 3'(i); expect_rd(CV0, CV1); step();
    end
    ren = 1'b0;
    repeat (4) step();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/distro_ram_dp.md
Name: distro_ram_dp

Overview:
Parametrised simple-dual-port distributed RAM. It is the next generation of the single-port DistroRAM.
- Separate write and read ports, with a registered read and an optional extra output stage.
- Configurable write-to-read collision forwarding.
- Built-in clear sequencer that initialises every word after reset or on request.
- Used for per-channel state tables and small lookup buffers in the datapath, where a known post-reset content is required.

Parameters:
WIDTH, 8, data word width in bits (>=1)
LOG_DEP, 3, address width; DEPTH = 1 << LOG_DEP words
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles
BYPASS, 1, 1 = same-cycle same-address read returns din (write-first); 0 = returns old contents (read-first)
CLEAR_VAL, 0, WIDTH-bit value written to every word by the clear sequencer

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
clear  in  1  single-cycle request to re-initialise all words to CLEAR_VAL
busy  out  1  high while the clear sweep is in progress; ports are ignored
wen  in  1  write enable
waddr  in  LOG_DEP  write address
din  in  WIDTH  write data
ren  in  1  read enable
raddr  in  LOG_DEP  read address
dout  out  WIDTH  read data
dout_valid  out  1  one-cycle pulse marking dout as the result of an accepted read

Behaviour:
- FSM states: IDLE and CLEAR. Clear pointer clr_ptr is LOG_DEP bits wide. busy = (state == CLEAR), registered.
- Reset (any cycle reset=1):
  - state <= CLEAR, clr_ptr <= 0.
  - dout <= 0, dout_valid <= 0, output-stage registers <= 0.
  - No array write takes place.
  - busy reads 1 after the reset edge.
- CLEAR state: each edge writes CLEAR_VAL to mem[clr_ptr] and increments clr_ptr.
  - On the edge that writes DEPTH-1: state <= IDLE, clr_ptr wraps to 0.
  - busy is therefore high for exactly DEPTH cycles after reset release.
- During CLEAR:
  - wen, ren and clear are ignored; clear does not restart the sweep.
  - dout_valid = 0; dout holds its value.
- IDLE, clear=1: state <= CLEAR next edge.
  - Any wen/ren presented in that same cycle is still performed normally.
- IDLE, wen=1: mem[waddr] <= din on the edge.
- IDLE, ren=1, OUT_REG=0: on the edge, dout <= mem[raddr] and dout_valid <= 1. Latency 1.
- OUT_REG=1: the same value passes through a second register stage.
  - dout and dout_valid appear 2 edges after ren.
  - Back-to-back reads give one result per cycle.
- No accepted read: dout_valid <= 0 and dout holds its last value. This applies to both stages.
- Collision (wen & ren & waddr == raddr, IDLE):
  - BYPASS=1: read returns din.
  - BYPASS=0: read returns pre-write contents.
  - The array is updated in both cases.
- Different addresses in the same cycle: independent, no interaction.
- Addresses are full-range (no out-of-range case). clr_ptr wraps modulo DEPTH.
- Reset mid-sweep: sweep restarts from address 0 and busy stays high for a full DEPTH cycles after release.
- Reset with OUT_REG=1: a read in flight is discarded; no dout_valid pulse appears after reset.
- Array storage has no reset beyond the sweep. Reads are only meaningful after busy falls.

Test Plan:
(WIDTH=8, LOG_DEP=3, CLEAR_VAL=0 unless stated.)
1. Post-reset clear:
   - Stimulus: reset high 2 cycles, then low; then read addresses 0..7.
   - Required: busy=1 for exactly 8 cycles; all 8 reads return 00 with dout_valid=1.
   - Repeat with CLEAR_VAL=8'h5A: all reads return 5A.
2. Write/readback:
   - Stimulus: write CA@0, BE@2, DF@5, EA@1, 99@4, 80@3, 35@7, 22@6; then back-to-back reads 0..7.
   - Required: dout = CA, EA, BE, 80, 99, DF, 22, 35 on consecutive cycles, valid each cycle.
   - First result 1 edge after first ren (OUT_REG=0) or 2 edges (OUT_REG=1).
3. Collision: with BE@2 stored, wen=1, waddr=2, din=55, ren=1, raddr=2 in the same cycle.
   - Required: BYPASS=1 gives dout=55; BYPASS=0 gives dout=BE.
   - A following read of address 2 gives 55 in both cases.
4. Clear request:
   - Stimulus: pulse clear in IDLE with data loaded; during busy issue write AA@3 and read 3.
   - Required: busy high 8 cycles, dout_valid stays 0, dout unchanged; after busy falls, reads of 0..7 all return 00.
5. Reset mid-sweep: assert reset while clr_ptr=4.
   - Required: busy stays high and remains high 8 full cycles after release.
   - No dout_valid pulse appears; the in-flight OUT_REG=1 read is dropped.
6. Hold: idle cycles after a read returning 99.
   - Required: dout stays 99 and dout_valid=0 on every idle cycle.
